// File: rtl/ota.sv
// ota: discrete-time single-pole op-amp model with saturation, optional rail clipping
// and optional slew limiting (slew limiting compiled in by OTA_SLEW_LIMIT_EN).
module ota #(
  parameter int unsigned GAIN       = 70,
  parameter int          TAU_SHIFT  = 3,
  parameter int          SLEW_SHIFT = 4,
  parameter int          ETOL       = 4,
  parameter int          EN_LCC     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] vdd,
  input  logic signed [15:0] vss,
  input  logic        [15:0] ibias,
  input  logic signed [15:0] inp,
  input  logic signed [15:0] inn,
  output logic signed [15:0] out,
  output logic               settled
);
  localparam logic signed [24:0] G     = 25'(GAIN);
  localparam logic signed [24:0] PMAX  = 25'sd32767;
  localparam logic signed [24:0] PMIN  = -25'sd32768;
  localparam logic signed [18:0] SMAX  = 19'sd32767;
  localparam logic signed [18:0] SMIN  = -19'sd32768;
  localparam logic signed [17:0] TOL   = 18'(ETOL);
  logic signed [15:0] out_q, out_d, target, sat, clip;
  logic               settled_q, settled_d;
  logic signed [16:0] diff;
  logic signed [24:0] prod;
  logic signed [17:0] err, mag, step, stp;
  logic signed [18:0] sum;
`ifdef OTA_SLEW_LIMIT_EN
  logic signed [17:0] lim;
  assign lim = $signed({2'b00, ibias >> SLEW_SHIFT});
  assign stp = step > lim ? lim : step < -lim ? -lim : step;
`else
  logic unused_ibias;
  assign unused_ibias = ^ibias;
  assign stp = step;
`endif
  always_comb begin
    diff      = 17'(inp) - 17'(inn);
    prod      = 25'(diff) * G;
    target    = prod > PMAX ? 16'sh7fff : prod < PMIN ? 16'sh8000 : prod[15:0];
    err       = 18'(target) - 18'(out_q);
    mag       = err < 0 ? -err : err;
    step      = err >>> TAU_SHIFT;
    sum       = 19'(out_q) + 19'(stp);
    sat       = sum > SMAX ? 16'sh7fff : sum < SMIN ? 16'sh8000 : sum[15:0];
    clip      = EN_LCC == 0 ? sat : vdd <= vss ? vss : sat > vdd ? vdd : sat < vss ? vss : sat;
    settled_d = mag <= TOL;
    out_d     = settled_d ? out_q : clip;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= '0;
      settled_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      settled_q <= settled_d;
    end
  end
  assign out     = out_q;
  assign settled = settled_q;
endmodule

// File: tb/tb_ota.sv
// tb_ota: scoreboard bench for ota; stimulus pushes hand-computed expectations,
// a monitor pops one per cycle after the clock edge and compares.
module tb_ota;
  logic               clk = 1'b0;
  logic               rst, fb, settled;
  logic signed [15:0] vdd, vss, inp, inn, inn_r, out;
  logic        [15:0] ibias;
  int passed = 0, total = 0;
  typedef struct {
    logic signed [15:0] o;
    logic               s;
    string              n;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int hi_seq[6]   = '{4095, 7679, 8192, 8192, 8192, 8192};
  int neg_seq[18] = '{-9, -17, -24, -30, -35, -40, -44, -48, -51, -54, -56, -58, -60, -62, -63, -64, -65, -66};
  int pos_seq[21] = '{8, 15, 21, 27, 32, 36, 40, 43, 46, 49, 51, 53, 55, 56, 57, 58, 59, 60, 61, 62, 63};

  always #5 clk = ~clk;
  assign inn = fb ? out : inn_r;

  ota dut (
    .clk(clk), .rst(rst), .vdd(vdd), .vss(vss), .ibias(ibias),
    .inp(inp), .inn(inn), .out(out), .settled(settled)
  );

  task automatic tick(input int eo, input logic es, input string nm);
    exp_t x;
    x.o = 16'(eo);
    x.s = es;
    x.n = nm;
    q.push_back(x);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (out === e.o) passed++;
      else $display("FAIL %s out: got %0d want %0d", e.n, out, e.o);
      total++;
      if (settled === e.s) passed++;
      else $display("FAIL %s settled: got %0b want %0b", e.n, settled, e.s);
    end
  end

  initial begin
    rst = 1'b1; fb = 1'b0; vdd = 16'sd8192; vss = 16'sd0; ibias = 16'hffff;
    inp = 16'sd4096; inn_r = 16'sd0;
    @(negedge clk);
    tick(0, 0, "rst_a"); tick(0, 0, "rst_b");
    rst = 1'b0;
    tick(4095, 0, "first_upd"); tick(7679, 0, "second_upd");
    rst = 1'b1; tick(0, 0, "mid_rst");
    rst = 1'b0;
    tick(4095, 0, "restart"); tick(7679, 0, "restart2");
    tick(8192, 0, "clip_vdd"); tick(8192, 0, "clip_vdd2");
    rst = 1'b1; inp = 16'sd1000; tick(0, 0, "rst_hi");
    rst = 1'b0;
    foreach (hi_seq[i]) tick(hi_seq[i], 0, "rail_hi");
    rst = 1'b1; vss = -16'sd8192; inp = -16'sd1; tick(0, 0, "rst_neg");
    rst = 1'b0;
    foreach (neg_seq[i]) tick(neg_seq[i], 0, "neg_floor");
    tick(-66, 1, "etol_hold"); tick(-66, 1, "etol_hold2");
    rst = 1'b1; vss = 16'sd0; inp = 16'sd1; tick(0, 0, "rst_pos");
    rst = 1'b0;
    foreach (pos_seq[i]) tick(pos_seq[i], 0, "pos_approach");
    tick(63, 0, "zero_step"); tick(63, 0, "zero_step2");
    rst = 1'b1; vdd = 16'sd100; vss = 16'sd200; inp = 16'sd1000; tick(0, 0, "rst_inv");
    rst = 1'b0;
    tick(200, 0, "inv_rail"); tick(200, 0, "inv_rail2"); tick(200, 0, "inv_rail3");
    inp = -16'sd1000;
    tick(200, 0, "inv_rail_neg"); tick(200, 0, "inv_rail_neg2");
    rst = 1'b1; vdd = 16'sd8192; vss = 16'sd0; inp = 16'sd0; fb = 1'b1; tick(0, 0, "rst_uf");
    rst = 1'b0;
    tick(0, 1, "uf_idle");
    inp = 16'sd4096;
    tick(4095, 0, "uf_step1"); tick(3591, 0, "uf_step2"); tick(7238, 0, "uf_step3");
`ifdef OTA_SLEW_LIMIT_EN
    tick(3143, 0, "uf_step4");
`else
    tick(2237, 0, "uf_step4");
`endif
    rst = 1'b1; fb = 1'b0; inp = 16'sd1000; ibias = 16'd0; tick(0, 0, "rst_ib");
    rst = 1'b0;
`ifdef OTA_SLEW_LIMIT_EN
    tick(0, 0, "ib0_freeze"); tick(0, 0, "ib0_freeze2"); tick(0, 0, "ib0_freeze3");
    ibias = 16'd1100;
    tick(68, 0, "slew1"); tick(136, 0, "slew2"); tick(204, 0, "slew3");
`else
    tick(4095, 0, "ib_ignored"); tick(7679, 0, "ib_ignored2");
    ibias = 16'd1100;
    tick(8192, 0, "ib_ignored3"); tick(8192, 0, "ib_ignored4");
`endif
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      total++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
